mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-serial memory engine between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between PCReg/IF and MEM on one side and the memory engine on the other.
- Selects one request at a time and issues it to the engine as a single-cycle command.
- Routes the engine's completion and read data back to the owning requester.
- Cancels in-flight fetches on a PC jump and bounds IF starvation under load/store traffic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width for fetch, load and store.
- STREAK_MAX, 4, maximum consecutive LS grants while IF is waiting; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- if_valid_i  in  1  IF request pending; held until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_flush_i  in  1  PC jump; cancels the in-flight fetch.
- if_ready_o  out  1  one-cycle fetch-complete pulse.
- if_inst_o  out  DATA_W  fetched instruction; valid while if_ready_o is high.
- ls_valid_i  in  1  LS request pending; held until ls_ready_o.
- ls_wr_i  in  1  1 = store, 0 = load.
- ls_size_i  in  2  0 = byte, 1 = half, 2 = word.
- ls_addr_i  in  ADDR_W  load/store address.
- ls_wdata_i  in  DATA_W  store data.
- ls_ready_o  out  1  one-cycle LS-complete pulse.
- ls_rdata_o  out  DATA_W  load data; valid while ls_ready_o is high.
- eng_req_o  out  1  one-cycle command pulse to the engine.
- eng_wr_o  out  1  command is a write.
- eng_size_o  out  2  access size; always 2 for IF.
- eng_addr_o  out  ADDR_W  command address.
- eng_wdata_o  out  DATA_W  command write data.
- eng_done_i  in  1  engine completion pulse; at most one per eng_req_o.
- eng_rdata_i  in  DATA_W  engine read data; valid with eng_done_i.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE, streak counter is 0, drop flag is 0.
  - Reset asserted mid-transaction abandons it; no ready pulse is ever emitted for it.
- rdy = 0:
  - Every register holds, including outputs, so a pulse stays high.
  - Inputs are ignored except rst.
- All outputs are registered.
- FSM states are IDLE, BUSY_IF, BUSY_LS and RESP.
- IDLE:
  - Arbitration uses that cycle's valids.
  - LS only → grant LS.
  - IF only → grant IF.
  - Both valid → grant LS unless streak == STREAK_MAX, in which case grant IF.
  - Neither valid → stay in IDLE.
- On a grant:
  - Next cycle eng_req_o = 1 for exactly one cycle.
  - eng_addr_o, eng_wr_o, eng_size_o and eng_wdata_o are latched from the winner; IF forces wr = 0 and size = 2.
  - State moves to BUSY_IF or BUSY_LS.
  - Command fields hold stable until the next grant.
- Streak counter:
  - An LS grant with if_valid_i high increments it, saturating at STREAK_MAX.
  - An IF grant, or any IDLE cycle with if_valid_i low, clears it to 0.
- BUSY_x:
  - Waits for eng_done_i, with no timeout.
  - On eng_done_i: eng_rdata_i is latched into the owner's data output, the owner's ready is pulsed next cycle, and state goes to RESP.
  - ls_rdata_o is loaded only on loads and holds on stores.
- RESP:
  - Lasts exactly one cycle; the ready pulse is high during it.
  - Then returns to IDLE.
  - Guarantees the requester has deasserted valid (or presented a new request) before the next arbitration, so a request is never granted twice.
  - Minimum turnaround is grant + 1 command cycle + engine latency + 1 RESP cycle.
- Flush:
  - if_flush_i in BUSY_IF, including the same cycle as eng_done_i, sets drop.
  - On done with drop = 1: no if_ready_o, if_inst_o unchanged, drop cleared, state goes straight to IDLE (RESP skipped).
  - Flush in IDLE or RESP has no effect on arbitration; flush in RESP does not retract the already-issued if_ready_o.
  - Flush in BUSY_LS is ignored.
  - The engine always runs a cancelled fetch to completion; the arbiter never aborts the engine.
- Simultaneous events:
  - A flush and a new if_valid_i in the same IDLE cycle give a normal grant, with the address taken that cycle.
  - eng_done_i outside BUSY_x is ignored.
- Busy:
  - busy_o = 1 in BUSY_IF, BUSY_LS and RESP.
  - Requester inputs are ignored while busy.

Test Plan:
- IF only, addr 0x100, engine done 5 cycles after eng_req_o with 0x00A00093:
  - eng_req_o pulses once with addr 0x100, wr 0, size 2.
  - if_ready_o pulses once 1 cycle after done with if_inst_o = 0x00A00093.
  - No second eng_req_o while IF valid drops.
- IF (0x200) and LS load (0x1000, size 0) both valid in the same IDLE cycle:
  - LS is granted first and ls_ready_o pulses with ls_rdata_o = engine data.
  - IF is granted next, with IF valid held.
- STREAK_MAX = 2, IF valid throughout, LS store re-requested continuously:
  - Grant order is LS, LS, IF, LS.
  - The streak counter never exceeds 2.
- IF in flight, if_flush_i pulsed 2 cycles after eng_req_o:
  - The done pulse produces no if_ready_o and the arbiter returns to IDLE.
  - A new IF at 0x300 is granted the next cycle.
  - Repeat with flush on the same cycle as eng_done_i: same result.
- rst asserted mid-BUSY_LS with no clock edge required:
  - All outputs go to 0 immediately.
  - After release, the stale eng_done_i is ignored and no ls_ready_o appears.
- rdy held low 3 cycles during RESP:
  - ls_ready_o stays high for all 3 cycles, state holds, and the pulse ends 1 cycle after rdy returns.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS arbiter for the shared byte-serial memory engine
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_inst_o,
    input  logic              ls_valid_i,
    input  logic              ls_wr_i,
    input  logic [1:0]        ls_size_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_ready_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              eng_req_o,
    output logic              eng_wr_o,
    output logic [1:0]        eng_size_o,
    output logic [ADDR_W-1:0] eng_addr_o,
    output logic [DATA_W-1:0] eng_wdata_o,
    input  logic              eng_done_i,
    input  logic [DATA_W-1:0] eng_rdata_i,
    output logic              busy_o
);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state, w_state_nx;
    logic [SW-1:0]     r_streak, w_streak_nx;
    logic              r_drop, w_drop_nx;
    logic              r_eng_req, w_eng_req_nx;
    logic              r_eng_wr, w_eng_wr_nx;
    logic [1:0]        r_eng_size, w_eng_size_nx;
    logic [ADDR_W-1:0] r_eng_addr, w_eng_addr_nx;
    logic [DATA_W-1:0] r_eng_wdata, w_eng_wdata_nx;
    logic              r_if_ready, w_if_ready_nx;
    logic [DATA_W-1:0] r_if_inst, w_if_inst_nx;
    logic              r_ls_ready, w_ls_ready_nx;
    logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata_nx;
    logic              r_busy, w_busy_nx;
    logic              w_ls_wins;

    // LS has priority until IF has been passed over STREAK_MAX times in a row
    assign w_ls_wins = ls_valid_i && !(if_valid_i && (r_streak == STREAK_LIM));

    always_comb begin
        w_state_nx     = r_state;
        w_streak_nx    = r_streak;
        w_drop_nx      = r_drop;
        w_eng_req_nx   = 1'b0;
        w_eng_wr_nx    = r_eng_wr;
        w_eng_size_nx  = r_eng_size;
        w_eng_addr_nx  = r_eng_addr;
        w_eng_wdata_nx = r_eng_wdata;
        w_if_ready_nx  = 1'b0;
        w_if_inst_nx   = r_if_inst;
        w_ls_ready_nx  = 1'b0;
        w_ls_rdata_nx  = r_ls_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_ls_wins) begin
                    w_state_nx     = S_BUSY_LS;
                    w_eng_req_nx   = 1'b1;
                    w_eng_wr_nx    = ls_wr_i;
                    w_eng_size_nx  = ls_size_i;
                    w_eng_addr_nx  = ls_addr_i;
                    w_eng_wdata_nx = ls_wdata_i;
                    w_streak_nx    = !if_valid_i ? '0 :
                                     (r_streak == STREAK_LIM) ? r_streak : r_streak + SW'(1);
                end else if (if_valid_i) begin
                    w_state_nx     = S_BUSY_IF;
                    w_eng_req_nx   = 1'b1;
                    w_eng_wr_nx    = 1'b0;
                    w_eng_size_nx  = 2'd2;
                    w_eng_addr_nx  = if_addr_i;
                    w_eng_wdata_nx = '0;
                    w_streak_nx    = '0;
                end else begin
                    w_streak_nx    = '0;
                end
            end
            S_BUSY_IF: begin
                // a flushed fetch still runs to completion in the engine; only its result is dropped
                if (eng_done_i) begin
                    w_drop_nx = 1'b0;
                    if (r_drop || if_flush_i) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx    = S_RESP;
                        w_if_ready_nx = 1'b1;
                        w_if_inst_nx  = eng_rdata_i;
                    end
                end else if (if_flush_i) begin
                    w_drop_nx = 1'b1;
                end
            end
            S_BUSY_LS: begin
                if (eng_done_i) begin
                    w_state_nx    = S_RESP;
                    w_ls_ready_nx = 1'b1;
                    if (!r_eng_wr) begin
                        w_ls_rdata_nx = eng_rdata_i;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_drop      <= 1'b0;
            r_eng_req   <= 1'b0;
            r_eng_wr    <= 1'b0;
            r_eng_size  <= 2'd0;
            r_eng_addr  <= '0;
            r_eng_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_if_inst   <= '0;
            r_ls_ready  <= 1'b0;
            r_ls_rdata  <= '0;
            r_busy      <= 1'b0;
        end else if (rdy) begin
            r_state     <= w_state_nx;
            r_streak    <= w_streak_nx;
            r_drop      <= w_drop_nx;
            r_eng_req   <= w_eng_req_nx;
            r_eng_wr    <= w_eng_wr_nx;
            r_eng_size  <= w_eng_size_nx;
            r_eng_addr  <= w_eng_addr_nx;
            r_eng_wdata <= w_eng_wdata_nx;
            r_if_ready  <= w_if_ready_nx;
            r_if_inst   <= w_if_inst_nx;
            r_ls_ready  <= w_ls_ready_nx;
            r_ls_rdata  <= w_ls_rdata_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign if_ready_o  = r_if_ready;
    assign if_inst_o   = r_if_inst;
    assign ls_ready_o  = r_ls_ready;
    assign ls_rdata_o  = r_ls_rdata;
    assign eng_req_o   = r_eng_req;
    assign eng_wr_o    = r_eng_wr;
    assign eng_size_o  = r_eng_size;
    assign eng_addr_o  = r_eng_addr;
    assign eng_wdata_o = r_eng_wdata;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-timing model
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SMAX  = 2;
    localparam int NEVER = 32'h3fff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          if_valid_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic          if_ready_o;
    logic [DW-1:0] if_inst_o;
    logic          ls_valid_i;
    logic          ls_wr_i;
    logic [1:0]    ls_size_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic          ls_ready_o;
    logic [DW-1:0] ls_rdata_o;
    logic          eng_req_o;
    logic          eng_wr_o;
    logic [1:0]    eng_size_o;
    logic [AW-1:0] eng_addr_o;
    logic [DW-1:0] eng_wdata_o;
    logic          eng_done_i;
    logic [DW-1:0] eng_rdata_i;
    logic          busy_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ready_o(if_ready_o), .if_inst_o(if_inst_o),
        .ls_valid_i(ls_valid_i), .ls_wr_i(ls_wr_i), .ls_size_i(ls_size_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .ls_ready_o(ls_ready_o), .ls_rdata_o(ls_rdata_o),
        .eng_req_o(eng_req_o), .eng_wr_o(eng_wr_o), .eng_size_o(eng_size_o),
        .eng_addr_o(eng_addr_o), .eng_wdata_o(eng_wdata_o),
        .eng_done_i(eng_done_i), .eng_rdata_i(eng_rdata_i), .busy_o(busy_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // timeline of the current transaction in logical (rdy-high) cycles
    int L, t_req, t_done, t_rif, t_rls, t_free, owner, streak;
    bit drop, force_done;
    logic          p_wr, m_wr;
    logic [1:0]    p_size, m_size;
    logic [AW-1:0] p_addr, m_addr;
    logic [DW-1:0] p_wdata, m_wdata, m_inst, m_ldata, pend_data;
    bit            q_if_v, q_ls_v, q_ls_wr;
    logic [1:0]    q_ls_sz;
    logic [AW-1:0] q_if_a, q_ls_a;
    logic [DW-1:0] q_ls_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (L=%0d)", tag, obs, exp, L);
        end
    endtask

    task automatic model_reset();
        t_req = -10; t_done = -10; t_rif = -10; t_rls = -10; t_free = L;
        owner = 0; streak = 0; drop = 0;
        m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_inst = 0; m_ldata = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_eng_req"}, 64'(eng_req_o), 64'd0);
        chk({tag, "_eng_addr"}, 64'(eng_addr_o), 64'd0);
        chk({tag, "_eng_misc"}, 64'({eng_wr_o, eng_size_o, eng_wdata_o}), 64'd0);
        chk({tag, "_readies"}, 64'({if_ready_o, ls_ready_o}), 64'd0);
        chk({tag, "_data"}, 64'({if_inst_o, ls_rdata_o}), 64'd0);
    endtask

    task automatic new_ls();
        q_ls_v = 1; q_ls_wr = 1'($urandom); q_ls_sz = 2'($urandom_range(0, 2));
        q_ls_a = $urandom; q_ls_d = $urandom;
    endtask

    task automatic step();
        logic f;
        @(negedge clk);
        if (L == t_req) begin
            m_addr = p_addr; m_wr = p_wr; m_size = p_size; m_wdata = p_wdata;
        end
        if (L == t_rif) m_inst = pend_data;
        if (L == t_rls && !m_wr) m_ldata = pend_data;
        chk("busy", 64'(busy_o), 64'(L < t_free));
        chk("eng_req", 64'(eng_req_o), 64'(L == t_req));
        chk("if_ready", 64'(if_ready_o), 64'(L == t_rif));
        chk("ls_ready", 64'(ls_ready_o), 64'(L == t_rls));
        chk("eng_addr", 64'(eng_addr_o), 64'(m_addr));
        chk("eng_wr", 64'(eng_wr_o), 64'(m_wr));
        chk("eng_size", 64'(eng_size_o), 64'(m_size));
        chk("eng_wdata", 64'(eng_wdata_o), 64'(m_wdata));
        chk("if_inst", 64'(if_inst_o), 64'(m_inst));
        chk("ls_rdata", 64'(ls_rdata_o), 64'(m_ldata));
        if ($urandom_range(0, 7) == 0) begin
            // stalled cycle: every input is noise and must be ignored
            rdy = 0;
            if_valid_i = 1'($urandom); if_addr_i = $urandom; if_flush_i = 1'($urandom);
            ls_valid_i = 1'($urandom); ls_wr_i = 1'($urandom); ls_size_i = 2'($urandom);
            ls_addr_i = $urandom; ls_wdata_i = $urandom;
            eng_done_i = 1'($urandom); eng_rdata_i = $urandom;
        end else begin
            if (L == t_rif) begin
                q_if_v = ($urandom_range(0, 1) == 1); q_if_a = $urandom;
            end else if (!q_if_v && $urandom_range(0, 3) == 0) begin
                q_if_v = 1; q_if_a = $urandom;
            end
            f = ($urandom_range(0, 9) == 0);
            if (f) begin
                q_if_v = 1; q_if_a = $urandom;
            end
            if (L == t_rls) begin
                if ($urandom_range(0, 3) != 0) new_ls(); else q_ls_v = 0;
            end else if (!q_ls_v && $urandom_range(0, 1) == 0) begin
                new_ls();
            end
            rdy = 1;
            if_valid_i = q_if_v; if_addr_i = q_if_a; if_flush_i = f;
            ls_valid_i = q_ls_v; ls_wr_i = q_ls_wr; ls_size_i = q_ls_sz;
            ls_addr_i = q_ls_a; ls_wdata_i = q_ls_d;
            eng_rdata_i = $urandom;
            eng_done_i = (owner != 0 && L == t_done) || force_done ||
                         (L > t_done && $urandom_range(0, 7) == 0);
            force_done = 0;
            if (owner == 1 && L >= t_req && f) drop = 1;
            if (owner != 0 && L == t_done) begin
                if (owner == 1 && drop) begin
                    t_free = L + 1;
                end else begin
                    if (owner == 1) t_rif = L + 1; else t_rls = L + 1;
                    pend_data = eng_rdata_i;
                    t_free = L + 2;
                end
                owner = 0; drop = 0;
            end else if (L >= t_free) begin
                if (q_ls_v && !(q_if_v && streak == SMAX)) begin
                    owner = 2; p_wr = q_ls_wr; p_size = q_ls_sz; p_addr = q_ls_a; p_wdata = q_ls_d;
                    streak = q_if_v ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
                end else if (q_if_v) begin
                    owner = 1; p_wr = 0; p_size = 2'd2; p_addr = q_if_a; p_wdata = 0;
                    streak = 0;
                end else begin
                    streak = 0;
                end
                if (owner != 0) begin
                    t_req = L + 1; t_done = L + 1 + $urandom_range(1, 5); t_free = NEVER;
                end
            end
            L++;
        end
    endtask

    initial begin
        bit found;
        rst = 1; rdy = 1;
        if_valid_i = 0; if_addr_i = 0; if_flush_i = 0;
        ls_valid_i = 0; ls_wr_i = 0; ls_size_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
        eng_done_i = 0; eng_rdata_i = 0;
        q_if_v = 0; q_ls_v = 0; q_if_a = 0; q_ls_a = 0; q_ls_d = 0; q_ls_wr = 0; q_ls_sz = 0;
        p_wr = 0; p_size = 0; p_addr = 0; p_wdata = 0; pend_data = 0;
        L = 0; force_done = 0;
        model_reset();
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4000; i++) step();

        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (owner == 2 && L >= t_req && L < t_done && rdy) found = 1;
        end
        chk("find_busy_ls", 64'(found), 64'd1);
        if (found) begin
            @(posedge clk);
            #1;
            chk("pre_rst_busy", 64'(busy_o), 64'd1);
            #1;
            rst = 1;
            #1;
            check_outputs_zero("async_rst");
            if_valid_i = 0; ls_valid_i = 0; if_flush_i = 0; eng_done_i = 0;
            repeat (2) @(negedge clk);
            check_outputs_zero("rst_hold");
            rst = 0;
            q_if_v = 0; q_ls_v = 0;
            model_reset();
            force_done = 1;
            for (int i = 0; i < 300; i++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
